// File: rtl/tag_lookup_ctrl_if.sv
// rtl/tag_lookup_ctrl_if.sv - request, response, tag-compare and refill signals of the tag lookup controller
interface tag_lookup_ctrl_if #(
  parameter int NR_WAYS    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH  = 44,
  parameter int LINE_WIDTH = 128
) ();
  // upstream lookup request
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic [ADDR_WIDTH-1:0]         req_addr_i;
  // upstream response
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic [LINE_WIDTH-1:0]         rsp_data_o;
  logic                          rsp_hit_o;
  logic [NR_WAYS-1:0]            rsp_way_o;
  // tag comparator port
  logic [NR_WAYS-1:0]            tc_req_o;
  logic                          tc_gnt_i;
  logic [ADDR_WIDTH-1:0]         tc_addr_o;
  logic [TAG_WIDTH-1:0]          tc_tag_o;
  logic [NR_WAYS-1:0]            hit_way_i;
  logic [NR_WAYS-1:0]            valid_way_i;
  logic [NR_WAYS*LINE_WIDTH-1:0] way_data_i;
  // refill port
  logic                          miss_req_o;
  logic                          miss_gnt_i;
  logic [ADDR_WIDTH-1:0]         miss_addr_o;
  logic [NR_WAYS-1:0]            miss_way_o;
  logic                          miss_done_i;
  logic [LINE_WIDTH-1:0]         miss_data_i;
  // statistics
  logic [31:0]                   hit_cnt_o;
  logic [31:0]                   miss_cnt_o;

  // controller side
  modport master (
    input  req_valid_i, req_addr_i, rsp_ready_i, tc_gnt_i, hit_way_i, valid_way_i,
           way_data_i, miss_gnt_i, miss_done_i, miss_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_way_o, tc_req_o,
           tc_addr_o, tc_tag_o, miss_req_o, miss_addr_o, miss_way_o, hit_cnt_o, miss_cnt_o
  );

  // requester / comparator / refill side
  modport slave (
    output req_valid_i, req_addr_i, rsp_ready_i, tc_gnt_i, hit_way_i, valid_way_i,
           way_data_i, miss_gnt_i, miss_done_i, miss_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_way_o, tc_req_o,
           tc_addr_o, tc_tag_o, miss_req_o, miss_addr_o, miss_way_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - single-outstanding tag lookup controller with victim selection and refill
module tag_lookup_ctrl #(
  parameter int NR_WAYS     = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44,
  parameter int LINE_WIDTH  = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tag_lookup_ctrl_if.master bus
);

  localparam int WAY_IDX_W = $clog2(NR_WAYS);

  typedef enum logic [2:0] {
    IDLE,
    TAG_REQ,
    TAG_CMP,
    RESP,
    MISS_REQ,
    MISS_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic [NR_WAYS-1:0]    way_q, way_d;
  logic                  hit_q, hit_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [NR_WAYS-1:0]    hit_oh;
  logic [NR_WAYS-1:0]    inv_oh;
  logic [NR_WAYS-1:0]    lfsr_oh;
  logic [LINE_WIDTH-1:0] hit_data;
  logic [7:0]            lfsr_next;

  // Lowest set bit of v as a one-hot vector; zero when v is zero.
  function automatic logic [NR_WAYS-1:0] lowest_one(input logic [NR_WAYS-1:0] v);
    logic [NR_WAYS-1:0] res;
    res = '0;
    for (int w = NR_WAYS - 1; w >= 0; w--) begin
      if (v[w]) begin
        res    = '0;
        res[w] = 1'b1;
      end
    end
    return res;
  endfunction

  // Way selection helpers: resolved hit way and its data, first invalid way, LFSR victim.
  always_comb begin
    hit_oh   = lowest_one(bus.hit_way_i);
    inv_oh   = lowest_one(~bus.valid_way_i);
    hit_data = '0;
    for (int w = 0; w < NR_WAYS; w++) begin
      if (hit_oh[w]) hit_data = bus.way_data_i[w*LINE_WIDTH +: LINE_WIDTH];
    end
    lfsr_oh = '0;
    lfsr_oh[lfsr_q[WAY_IDX_W-1:0]] = 1'b1;
    lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Address-derived outputs are driven continuously so the comparator sees a stable tag
  // in both TAG_REQ and TAG_CMP, and the refill address holds through MISS_REQ.
  assign bus.tc_addr_o   = {{(ADDR_WIDTH-INDEX_WIDTH){1'b0}}, addr_q[INDEX_WIDTH-1:0]};
  assign bus.tc_tag_o    = addr_q[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH];
  assign bus.miss_addr_o = addr_q;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_way_o   = way_q;
  assign bus.rsp_hit_o   = hit_q;
  assign bus.hit_cnt_o   = hit_cnt_q;
  assign bus.miss_cnt_o  = miss_cnt_q;

  // FSM next state, datapath updates and state-decoded handshake outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    way_d           = way_q;
    hit_d           = hit_q;
    lfsr_d          = lfsr_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    bus.req_ready_o = 1'b0;
    bus.tc_req_o    = '0;
    bus.miss_req_o  = 1'b0;
    bus.miss_way_o  = '0;
    bus.rsp_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        // ready stays low while reset is held so nothing is accepted during reset
        bus.req_ready_o = !rst_i;
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          state_d = TAG_REQ;
        end
      end
      TAG_REQ: begin
        bus.tc_req_o = '1;
        if (bus.tc_gnt_i) state_d = TAG_CMP;
      end
      TAG_CMP: begin
        if (|bus.hit_way_i) begin
          way_d  = hit_oh;
          data_d = hit_data;
          hit_d  = 1'b1;
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          state_d = RESP;
        end else begin
          hit_d = 1'b0;
          if (|inv_oh) begin
            way_d = inv_oh;
          end else begin
            way_d  = lfsr_oh;
            lfsr_d = lfsr_next;
          end
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        bus.miss_req_o = 1'b1;
        bus.miss_way_o = way_q;
        if (bus.miss_gnt_i) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (bus.miss_done_i) begin
          data_d  = bus.miss_data_i;
          hit_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      lfsr_q     <= 8'h01;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      lfsr_q     <= lfsr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - directed self-checking bench for tag_lookup_ctrl
module tb_tag_lookup_ctrl;
  localparam int NW = 4;
  localparam int AW = 64;
  localparam int IW = 12;
  localparam int TW = 44;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  tag_lookup_ctrl_if #(.NR_WAYS(NW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus ();

  tag_lookup_ctrl #(
    .NR_WAYS(NW), .ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Full lookup that misses; returns at the negedge after the response handshake.
  task automatic run_miss(input string tag, input logic [AW-1:0] addr, input logic [NW-1:0] valid,
                          input logic [NW-1:0] exp_way, input logic [LW-1:0] data);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.tc_gnt_i    = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.hit_way_i   = '0;
    bus.valid_way_i = valid;
    tick();
    bus.hit_way_i   = 4'b1111;
    bus.valid_way_i = 4'b0000;
    chk({tag, ".miss_req"}, 128'(bus.miss_req_o), 128'd1);
    chk({tag, ".miss_way"}, 128'(bus.miss_way_o), 128'(exp_way));
    bus.miss_gnt_i = 1'b1;
    tick();
    bus.miss_gnt_i  = 1'b0;
    bus.miss_done_i = 1'b1;
    bus.miss_data_i = data;
    tick();
    bus.miss_done_i = 1'b0;
    chk({tag, ".rsp_valid"}, 128'(bus.rsp_valid_o), 128'd1);
    chk({tag, ".rsp_data"}, 128'(bus.rsp_data_o), 128'(data));
    chk({tag, ".rsp_hit"}, 128'(bus.rsp_hit_o), 128'd0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.tc_gnt_i    = 1'b0;
    bus.hit_way_i   = 4'b1111;
    bus.valid_way_i = 4'b0000;
    bus.way_data_i  = '0;
    bus.miss_gnt_i  = 1'b0;
    bus.miss_done_i = 1'b0;
    bus.miss_data_i = '0;

    // reset state
    tick(); tick();
    chk("rst.req_ready", 128'(bus.req_ready_o), 128'd0);
    chk("rst.tc_req", 128'(bus.tc_req_o), 128'd0);
    chk("rst.hit_cnt", 128'(bus.hit_cnt_o), 128'd0);
    chk("rst.rsp_valid", 128'(bus.rsp_valid_o), 128'd0);
    rst = 1'b0;
    tick();
    chk("rst.req_ready_after", 128'(bus.req_ready_o), 128'd1);

    // hit, zero-wait grant, way 2
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h0000_0000_8000_1040;
    bus.tc_gnt_i    = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    chk("hit.tc_req", 128'(bus.tc_req_o), 128'hF);
    chk("hit.tc_tag", 128'(bus.tc_tag_o), 128'h8_0001);
    chk("hit.tc_addr", 128'(bus.tc_addr_o), 128'h040);
    tick();
    bus.hit_way_i   = 4'b0100;
    bus.valid_way_i = 4'b1111;
    bus.way_data_i  = {{32{4'h3}}, {32{4'hA}}, {32{4'h1}}, {32{4'h0}}};
    chk("hit.tc_req_cmp", 128'(bus.tc_req_o), 128'h0);
    chk("hit.rsp_early", 128'(bus.rsp_valid_o), 128'd0);
    tick();
    bus.hit_way_i = 4'b1111;
    chk("hit.rsp_valid", 128'(bus.rsp_valid_o), 128'd1);
    chk("hit.rsp_data", bus.rsp_data_o, {32{4'hA}});
    chk("hit.rsp_way", 128'(bus.rsp_way_o), 128'b0100);
    chk("hit.rsp_hit", 128'(bus.rsp_hit_o), 128'd1);
    chk("hit.hit_cnt", 128'(bus.hit_cnt_o), 128'd1);
    chk("hit.req_ready", 128'(bus.req_ready_o), 128'd0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("hit.idle_ready", 128'(bus.req_ready_o), 128'd1);
    chk("hit.idle_rsp", 128'(bus.rsp_valid_o), 128'd0);

    // grant stall of three cycles
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h0000_0012_3456_7ABC;
    bus.tc_gnt_i    = 1'b0;
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall.tc_req", 128'(bus.tc_req_o), 128'hF);
      chk("stall.tc_tag", 128'(bus.tc_tag_o), 128'h12_3456_7);
      chk("stall.rsp", 128'(bus.rsp_valid_o), 128'd0);
      tick();
    end
    bus.tc_gnt_i = 1'b1;
    chk("stall.tc_req_gnt", 128'(bus.tc_req_o), 128'hF);
    tick();
    bus.hit_way_i  = 4'b0001;
    bus.way_data_i = {{32{4'h3}}, {32{4'h2}}, {32{4'h1}}, {32{4'hC}}};
    chk("stall.cmp_rsp", 128'(bus.rsp_valid_o), 128'd0);
    tick();
    bus.hit_way_i = 4'b1111;
    chk("stall.rsp_valid", 128'(bus.rsp_valid_o), 128'd1);
    chk("stall.rsp_data", bus.rsp_data_o, {32{4'hC}});
    chk("stall.hit_cnt", 128'(bus.hit_cnt_o), 128'd2);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // miss with way 2 invalid; refill grant after two cycles, early done ignored
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h0000_0ABC_DEF0_1234;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.hit_way_i   = 4'b0000;
    bus.valid_way_i = 4'b1011;
    tick();
    bus.hit_way_i   = 4'b1111;
    bus.valid_way_i = 4'b0000;
    bus.miss_done_i = 1'b1;
    bus.miss_data_i = {32{4'hD}};
    for (int i = 0; i < 2; i++) begin
      chk("miss.req", 128'(bus.miss_req_o), 128'd1);
      chk("miss.way", 128'(bus.miss_way_o), 128'b0100);
      chk("miss.addr", 128'(bus.miss_addr_o), 128'h0ABC_DEF0_1234);
      tick();
    end
    chk("miss.miss_cnt", 128'(bus.miss_cnt_o), 128'd1);
    chk("miss.hit_cnt", 128'(bus.hit_cnt_o), 128'd2);
    bus.miss_done_i = 1'b0;
    bus.miss_gnt_i  = 1'b1;
    tick();
    bus.miss_gnt_i = 1'b0;
    chk("miss.wait_req", 128'(bus.miss_req_o), 128'd0);
    chk("miss.wait_rsp", 128'(bus.rsp_valid_o), 128'd0);
    bus.miss_done_i = 1'b1;
    bus.miss_data_i = {32{4'h5}};
    tick();
    bus.miss_done_i = 1'b0;
    chk("miss.rsp_valid", 128'(bus.rsp_valid_o), 128'd1);
    chk("miss.rsp_hit", 128'(bus.rsp_hit_o), 128'd0);
    chk("miss.rsp_data", bus.rsp_data_o, {32{4'h5}});
    chk("miss.rsp_way", 128'(bus.rsp_way_o), 128'b0100);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // three all-valid misses walk the LFSR 01, 02, 04
    run_miss("lfsr0", 64'h1000, 4'b1111, 4'b0010, {32{4'h6}});
    run_miss("lfsr1", 64'h2000, 4'b1111, 4'b0100, {32{4'h7}});
    run_miss("lfsr2", 64'h3000, 4'b1111, 4'b0001, {32{4'h8}});
    chk("lfsr.miss_cnt", 128'(bus.miss_cnt_o), 128'd4);

    // multi-hit resolved to lowest way, with response backpressure
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h4000;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.hit_way_i  = 4'b1010;
    bus.way_data_i = {{32{4'h3}}, {32{4'h2}}, {32{4'h9}}, {32{4'h0}}};
    tick();
    bus.hit_way_i   = 4'b1111;
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", 128'(bus.rsp_valid_o), 128'd1);
      chk("bp.rsp_way", 128'(bus.rsp_way_o), 128'b0010);
      chk("bp.rsp_data", bus.rsp_data_o, {32{4'h9}});
      chk("bp.req_ready", 128'(bus.req_ready_o), 128'd0);
      tick();
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("bp.hit_cnt", 128'(bus.hit_cnt_o), 128'd3);
    chk("bp.idle_ready", 128'(bus.req_ready_o), 128'd1);

    // reset while waiting for refill
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h5000;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.hit_way_i   = 4'b0000;
    bus.valid_way_i = 4'b0111;
    tick();
    bus.hit_way_i   = 4'b1111;
    bus.valid_way_i = 4'b0000;
    bus.miss_gnt_i  = 1'b1;
    tick();
    bus.miss_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.miss_req", 128'(bus.miss_req_o), 128'd0);
    chk("rstmid.rsp_valid", 128'(bus.rsp_valid_o), 128'd0);
    chk("rstmid.hit_cnt", 128'(bus.hit_cnt_o), 128'd0);
    chk("rstmid.miss_cnt", 128'(bus.miss_cnt_o), 128'd0);
    tick();
    chk("rstmid.req_ready", 128'(bus.req_ready_o), 128'd1);
    chk("rstmid.rsp_after", 128'(bus.rsp_valid_o), 128'd0);
    run_miss("rstlfsr", 64'h6000, 4'b1111, 4'b0010, {32{4'hE}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
